// File: rtl/rv32im_writeback_if.sv
//------------------------------------------------------------------------------
// Module : rv32im_writeback_if
// Brief  : Result channels from ALU, load unit and mul/div into writeback.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rv32im_writeback_if #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
);
  logic                alu_valid_i;
  logic                alu_ready_o;
  logic [REG_BITS-1:0] alu_rd_i;
  logic [XLEN-1:0]     alu_data_i;

  logic                mem_valid_i;
  logic                mem_ready_o;
  logic [REG_BITS-1:0] mem_rd_i;
  logic [XLEN-1:0]     mem_data_i;
  logic [2:0]          mem_funct3_i;
  logic [1:0]          mem_offset_i;

  logic                md_valid_i;
  logic                md_ready_o;
  logic [REG_BITS-1:0] md_rd_i;
  logic [XLEN-1:0]     md_data_i;

  // Producers drive results; writeback returns the accept strobes.
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output mem_valid_i, mem_rd_i, mem_data_i, mem_funct3_i, mem_offset_i,
    output md_valid_i, md_rd_i, md_data_i,
    input  alu_ready_o, mem_ready_o, md_ready_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  mem_valid_i, mem_rd_i, mem_data_i, mem_funct3_i, mem_offset_i,
    input  md_valid_i, md_rd_i, md_data_i,
    output alu_ready_o, mem_ready_o, md_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/rv32im_writeback.sv
//------------------------------------------------------------------------------
// Module : rv32im_writeback
// Brief  : Arbitrates ALU/load/mul-div results, formats loads, drives one
//          register write per cycle and tracks pending destinations.
//          Optional operand bypass: define RV32IM_WB_BYPASS_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rv32im_writeback #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  wire logic                clk_i,
  input  wire logic                rst_ni,
  rv32im_writeback_if.slave        bus,
  input  wire logic                issue_i,
  input  wire logic [REG_BITS-1:0] issue_rd_i,
  input  wire logic [REG_BITS-1:0] rs1_addr_i,
  input  wire logic [REG_BITS-1:0] rs2_addr_i,
  output logic                     raw_hazard_o,
  output logic                     waw_hazard_o,
  output logic                     reg_write_o,
  output logic [REG_BITS-1:0]      reg_rd_o,
  output logic [XLEN-1:0]          reg_data_o,
`ifdef RV32IM_WB_BYPASS_EN
  output logic                     fwd_rs1_o,
  output logic                     fwd_rs2_o,
  output logic [XLEN-1:0]          fwd_data_o,
`endif
  output logic                     data_ready_o
);

  localparam int NREGS = 2 ** REG_BITS;

  logic                mem_rdy, md_rdy, alu_rdy, xfer;
  logic [REG_BITS-1:0] sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic [XLEN-1:0]     load_data;

  logic                write_d, write_q;
  logic                commit_d, commit_q;
  logic                data_ready_d, data_ready_q;
  logic [REG_BITS-1:0] rd_d, rd_q;
  logic [XLEN-1:0]     data_d, data_q;
  logic [NREGS-1:0]    pending_d, pending_q;
  logic                fwd_rs1, fwd_rs2;

  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0] word,
    input logic [2:0]      funct3,
    input logic [1:0]      offset
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    // Halves only look at offset[1]; odd offsets are trapped before this stage.
    h = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
      3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
      default: fmt_load = word;
    endcase
  endfunction

  // Fixed priority mem > md > alu; nothing is accepted while reset is held.
  always_comb begin
    mem_rdy = rst_ni & bus.mem_valid_i;
    md_rdy  = rst_ni & bus.md_valid_i & ~bus.mem_valid_i;
    alu_rdy = rst_ni & bus.alu_valid_i & ~bus.mem_valid_i & ~bus.md_valid_i;
    xfer    = mem_rdy | md_rdy | alu_rdy;
  end

  assign bus.mem_ready_o = mem_rdy;
  assign bus.md_ready_o  = md_rdy;
  assign bus.alu_ready_o = alu_rdy;

  assign load_data = fmt_load(bus.mem_data_i, bus.mem_funct3_i, bus.mem_offset_i);

  always_comb begin
    sel_rd   = bus.alu_rd_i;
    sel_data = bus.alu_data_i;
    if (mem_rdy) begin
      sel_rd   = bus.mem_rd_i;
      sel_data = load_data;
    end else if (md_rdy) begin
      sel_rd   = bus.md_rd_i;
      sel_data = bus.md_data_i;
    end
  end

  always_comb begin
    commit_d     = xfer;
    write_d      = xfer & (sel_rd != '0);
    rd_d         = xfer ? sel_rd : rd_q;
    data_d       = xfer ? sel_data : data_q;
    // rd=0 commits still signal the register file so it re-reads operands.
    data_ready_d = commit_q;
  end

  // Clear on commit first so a same-cycle re-issue of that register wins.
  always_comb begin
    pending_d = pending_q;
    if (write_q) begin
      pending_d[rd_q] = 1'b0;
    end
    if (issue_i) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_q      <= 1'b0;
      commit_q     <= 1'b0;
      data_ready_q <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      pending_q    <= '0;
    end else begin
      write_q      <= write_d;
      commit_q     <= commit_d;
      data_ready_q <= data_ready_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      pending_q    <= pending_d;
    end
  end

`ifdef RV32IM_WB_BYPASS_EN
  always_comb begin
    fwd_rs1 = write_q & (rd_q != '0) & (rd_q == rs1_addr_i);
    fwd_rs2 = write_q & (rd_q != '0) & (rd_q == rs2_addr_i);
  end

  assign fwd_rs1_o  = fwd_rs1;
  assign fwd_rs2_o  = fwd_rs2;
  assign fwd_data_o = data_q;
`else
  always_comb begin
    fwd_rs1 = 1'b0;
    fwd_rs2 = 1'b0;
  end
`endif

  assign raw_hazard_o = (pending_q[rs1_addr_i] & ~fwd_rs1) |
                        (pending_q[rs2_addr_i] & ~fwd_rs2);
  assign waw_hazard_o = pending_q[issue_rd_i];

  assign reg_write_o  = write_q;
  assign reg_rd_o     = rd_q;
  assign reg_data_o   = data_q;
  assign data_ready_o = data_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32im_writeback.sv
//------------------------------------------------------------------------------
// Module : tb_rv32im_writeback
// Brief  : Directed self-checking bench for rv32im_writeback.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv32im_writeback;

  logic        clk;
  logic        rst_n;
  logic        issue;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        raw_hazard;
  logic        waw_hazard;
  logic        reg_write;
  logic [4:0]  reg_rd;
  logic [31:0] reg_data;
  logic        data_ready;
`ifdef RV32IM_WB_BYPASS_EN
  logic        fwd_rs1;
  logic        fwd_rs2;
  logic [31:0] fwd_data;
`endif

  int vectors = 0;
  int errs    = 0;

  rv32im_writeback_if #(.XLEN(32), .REG_BITS(5)) bus ();

  rv32im_writeback #(.XLEN(32), .REG_BITS(5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus.slave),
    .issue_i      (issue),
    .issue_rd_i   (issue_rd),
    .rs1_addr_i   (rs1),
    .rs2_addr_i   (rs2),
    .raw_hazard_o (raw_hazard),
    .waw_hazard_o (waw_hazard),
    .reg_write_o  (reg_write),
    .reg_rd_o     (reg_rd),
    .reg_data_o   (reg_data),
`ifdef RV32IM_WB_BYPASS_EN
    .fwd_rs1_o    (fwd_rs1),
    .fwd_rs2_o    (fwd_rs2),
    .fwd_data_o   (fwd_data),
`endif
    .data_ready_o (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  ld_f3  [5];
  logic [1:0]  ld_off [5];
  logic [31:0] ld_exp [5];

  initial begin
    ld_f3[0] = 3'b000; ld_off[0] = 2'd3; ld_exp[0] = 32'hFFFFFF80;
    ld_f3[1] = 3'b100; ld_off[1] = 2'd1; ld_exp[1] = 32'h0000007F;
    ld_f3[2] = 3'b001; ld_off[2] = 2'd2; ld_exp[2] = 32'hFFFF80FF;
    ld_f3[3] = 3'b101; ld_off[3] = 2'd0; ld_exp[3] = 32'h00007F01;
    ld_f3[4] = 3'b011; ld_off[4] = 2'd2; ld_exp[4] = 32'h80FF7F01;

    rst_n = 1'b0;
    issue = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd1; bus.alu_data_i = 32'h1;
    bus.mem_valid_i = 1'b0; bus.mem_rd_i = '0; bus.mem_data_i = '0;
    bus.mem_funct3_i = 3'b010; bus.mem_offset_i = '0;
    bus.md_valid_i = 1'b0; bus.md_rd_i = '0; bus.md_data_i = '0;

    // Reset state; a valid ALU result must not be accepted while in reset.
    #3;
    check("rst_write", {31'b0, reg_write}, 32'd0);
    check("rst_rd", {27'b0, reg_rd}, 32'd0);
    check("rst_data", reg_data, 32'd0);
    check("rst_dready", {31'b0, data_ready}, 32'd0);
    check("rst_alu_ready", {31'b0, bus.alu_ready_o}, 32'd0);
    step();
    bus.alu_valid_i = 1'b0;
    rst_n = 1'b1;

    // Basic ALU commit with scoreboard set/clear.
    step();
    issue = 1'b1; issue_rd = 5'd5;
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd5; bus.alu_data_i = 32'h1234;
    #1;
    check("alu_ready", {31'b0, bus.alu_ready_o}, 32'd1);
    check("md_ready_idle", {31'b0, bus.md_ready_o}, 32'd0);
    step();
    issue = 1'b0; bus.alu_valid_i = 1'b0;
    #1;
    check("t1_write", {31'b0, reg_write}, 32'd1);
    check("t1_rd", {27'b0, reg_rd}, 32'd5);
    check("t1_data", reg_data, 32'h00001234);
    check("t1_dready_early", {31'b0, data_ready}, 32'd0);
    check("t1_waw5", {31'b0, waw_hazard}, 32'd1);
    step();
    #1;
    check("t1_dready", {31'b0, data_ready}, 32'd1);
    check("t1_write_done", {31'b0, reg_write}, 32'd0);
    check("t1_waw5_clear", {31'b0, waw_hazard}, 32'd0);
    issue_rd = '0;

    // Three producers at once: mem, then md, then alu.
    bus.mem_valid_i = 1'b1; bus.mem_rd_i = 5'd1; bus.mem_data_i = 32'h80FF7F01;
    bus.mem_funct3_i = 3'b010; bus.mem_offset_i = 2'd0;
    bus.md_valid_i = 1'b1; bus.md_rd_i = 5'd2; bus.md_data_i = 32'h22;
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd3; bus.alu_data_i = 32'h33;
    #1;
    check("arb_mem_ready", {29'b0, bus.mem_ready_o, bus.md_ready_o, bus.alu_ready_o}, 32'b100);
    step();
    bus.mem_valid_i = 1'b0;
    #1;
    check("arb_w1", {31'b0, reg_write}, 32'd1);
    check("arb_w1_rd", {27'b0, reg_rd}, 32'd1);
    check("arb_w1_data", reg_data, 32'h80FF7F01);
    check("arb_md_ready", {29'b0, bus.mem_ready_o, bus.md_ready_o, bus.alu_ready_o}, 32'b010);
    step();
    bus.md_valid_i = 1'b0;
    #1;
    check("arb_w2", {31'b0, reg_write}, 32'd1);
    check("arb_w2_rd", {27'b0, reg_rd}, 32'd2);
    check("arb_w2_data", reg_data, 32'h22);
    check("arb_alu_ready", {29'b0, bus.mem_ready_o, bus.md_ready_o, bus.alu_ready_o}, 32'b001);
    step();
    bus.alu_valid_i = 1'b0;
    #1;
    check("arb_w3", {31'b0, reg_write}, 32'd1);
    check("arb_w3_rd", {27'b0, reg_rd}, 32'd3);
    check("arb_w3_data", reg_data, 32'h33);
    step();
    #1;
    check("arb_idle", {31'b0, reg_write}, 32'd0);

    // Load formatting, back-to-back.
    bus.mem_valid_i = 1'b1; bus.mem_rd_i = 5'd4; bus.mem_data_i = 32'h80FF7F01;
    for (int i = 0; i < 5; i++) begin
      bus.mem_funct3_i = ld_f3[i];
      bus.mem_offset_i = ld_off[i];
      step();
      if (i == 4) bus.mem_valid_i = 1'b0;
      #1;
      check($sformatf("load_%0d", i), reg_data, ld_exp[i]);
      check($sformatf("load_wr_%0d", i), {31'b0, reg_write}, 32'd1);
    end
    step();

    // Hazards on x7.
    issue = 1'b1; issue_rd = 5'd7;
    #1;
    check("waw_pre", {31'b0, waw_hazard}, 32'd0);
    step();
    issue = 1'b0; rs1 = 5'd7;
    #1;
    check("raw_rs1", {31'b0, raw_hazard}, 32'd1);
    check("waw_7", {31'b0, waw_hazard}, 32'd1);
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    check("raw_rs2", {31'b0, raw_hazard}, 32'd1);
    rs2 = 5'd0; rs1 = 5'd7;
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd7; bus.alu_data_i = 32'h77;
    step();
    bus.alu_valid_i = 1'b0;
    #1;
    check("h_write7", {27'b0, reg_rd}, 32'd7);
    step();
    #1;
    check("raw_clear", {31'b0, raw_hazard}, 32'd0);
    check("waw_clear", {31'b0, waw_hazard}, 32'd0);

    // Commit and re-issue of x7 in the same cycle: set wins.
    issue = 1'b1;
    step();
    issue = 1'b0;
    bus.alu_valid_i = 1'b1; bus.alu_data_i = 32'h78;
    #1;
    check("raw_reissued", {31'b0, raw_hazard}, 32'd1);
    step();
    bus.alu_valid_i = 1'b0; issue = 1'b1;
    #1;
    check("sw_write", {31'b0, reg_write}, 32'd1);
    step();
    issue = 1'b0;
    #1;
    check("raw_setwins", {31'b0, raw_hazard}, 32'd1);
    check("waw_setwins", {31'b0, waw_hazard}, 32'd1);
    bus.alu_valid_i = 1'b1; bus.alu_data_i = 32'h79;
    step();
    bus.alu_valid_i = 1'b0;
    step();
    #1;
    check("raw_final_clear", {31'b0, raw_hazard}, 32'd0);
    rs1 = '0; issue_rd = '0;

    // rd=0: no write strobe, data_ready still pulses.
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd0; bus.alu_data_i = 32'hDEAD;
    #1;
    check("x0_ready", {31'b0, bus.alu_ready_o}, 32'd1);
    step();
    bus.alu_valid_i = 1'b0;
    #1;
    check("x0_write", {31'b0, reg_write}, 32'd0);
    check("x0_dready_early", {31'b0, data_ready}, 32'd0);
    step();
    #1;
    check("x0_dready", {31'b0, data_ready}, 32'd1);
    check("x0_write_late", {31'b0, reg_write}, 32'd0);

    // Reset right after accepting rd=3 discards the write.
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd3; bus.alu_data_i = 32'h55;
    step();
    bus.alu_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", {31'b0, reg_write}, 32'd0);
    check("mid_rst_rd", {27'b0, reg_rd}, 32'd0);
    check("mid_rst_data", reg_data, 32'd0);
    check("mid_rst_dready", {31'b0, data_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    #1;
    check("post_rst_write", {31'b0, reg_write}, 32'd0);
    check("post_rst_dready", {31'b0, data_ready}, 32'd0);

`ifdef RV32IM_WB_BYPASS_EN
    issue = 1'b1; issue_rd = 5'd9;
    step();
    issue = 1'b0;
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd9; bus.alu_data_i = 32'hCAFE;
    step();
    bus.alu_valid_i = 1'b0; rs2 = 5'd9;
    #1;
    check("fwd_rs2", {31'b0, fwd_rs2}, 32'd1);
    check("fwd_rs1", {31'b0, fwd_rs1}, 32'd0);
    check("fwd_data", fwd_data, 32'h0000CAFE);
    check("fwd_raw", {31'b0, raw_hazard}, 32'd0);
    step();
    rs2 = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv32im_writeback.md
Name: rv32im_writeback

Overview:
- Writeback stage directly upstream of the register file.
- Arbitrates results from three producers: ALU, load unit and mul/div unit.
- Formats load data (byte/half extraction, sign/zero extension) and issues one register write per cycle.
- Keeps a pending-destination scoreboard that raises RAW/WAW hazards toward decode, and pulses data_ready_o so the register file re-reads operands after a commit.

Parameters:
- XLEN, 32, datapath width.
- REG_BITS, 5, register address width (32 architectural registers).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- alu_valid_i  input  1  ALU result valid.
- alu_ready_o  output  1  ALU result accepted this cycle.
- alu_rd_i  input  REG_BITS  ALU destination.
- alu_data_i  input  XLEN  ALU result.
- mem_valid_i  input  1  load data valid.
- mem_ready_o  output  1  load data accepted.
- mem_rd_i  input  REG_BITS  load destination.
- mem_data_i  input  XLEN  raw aligned word from the bus.
- mem_funct3_i  input  3  load type.
- mem_offset_i  input  2  byte address bits [1:0].
- md_valid_i  input  1  mul/div result valid.
- md_ready_o  output  1  mul/div result accepted.
- md_rd_i  input  REG_BITS  mul/div destination.
- md_data_i  input  XLEN  mul/div result.
- issue_i  input  1  decode issued an instruction writing issue_rd_i.
- issue_rd_i  input  REG_BITS  destination of the issued instruction.
- rs1_addr_i, rs2_addr_i  input  REG_BITS each  decode source operands.
- raw_hazard_o  output  1  rs1 or rs2 is pending.
- waw_hazard_o  output  1  issue_rd_i is pending; decode must not issue.
- reg_write_o  output  1  register file write strobe.
- reg_rd_o  output  REG_BITS  register file write address.
- reg_data_o  output  XLEN  register file write data.
- data_ready_o  output  1  one-cycle pulse the cycle after reg_write_o.

Behaviour:
- Reset (async, rst_ni=0):
  - reg_write_o=0, reg_rd_o=0, reg_data_o=0, data_ready_o=0.
  - Scoreboard cleared, all ready outputs 0.
- Arbitration is combinational, fixed priority mem > md > alu:
  - Exactly one ready is asserted, for the highest-priority valid source.
  - A transfer occurs when valid&ready.
  - Losers hold valid and data stable until accepted.
  - No ready is asserted while rst_ni=0.
- Latency: the accepted result appears on reg_write_o/reg_rd_o/reg_data_o exactly 1 cycle later, registered.
  - reg_write_o=1 for one cycle per transfer.
  - Back-to-back transfers give a write every cycle.
- rd=0 transfer:
  - Accepted normally, but reg_write_o stays 0 and data_ready_o still pulses.
  - The register file additionally masks x0.
- data_ready_o is reg_write_o (or an rd=0 commit) delayed by one cycle.
- Load formatting, applied before the output register:
  - 000 LB: byte at offset×8, sign-extended.
  - 001 LH: half at offset[1]×16, sign-extended.
  - 010 LW: whole word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half, zero-extended.
  - Other funct3 values: whole word passed unchanged.
  - offset[0] is ignored for halves; misalignment is trapped upstream.
- Scoreboard: a REG_BITS-indexed pending bit vector; bit 0 is never set.
  - issue_i with issue_rd_i≠0 sets pending[issue_rd_i].
  - A commit (the registered write) clears pending[reg_rd_o].
  - Set and clear of the same bit in the same cycle: set wins.
  - raw_hazard_o = pending[rs1_addr_i] | pending[rs2_addr_i], combinational.
  - waw_hazard_o = pending[issue_rd_i], combinational.
  - issue_i while waw_hazard_o=1 is a protocol violation; the bit stays set.
- Reset mid-operation: any in-flight registered write is discarded, with no write strobe after rst_ni deasserts.

Optional Feature:
- Macro: RV32IM_WB_BYPASS_EN.
- Defined:
  - Adds outputs fwd_rs1_o, fwd_rs2_o (1 bit) and fwd_data_o (XLEN).
  - When reg_write_o=1 and reg_rd_o equals rs1_addr_i (or rs2_addr_i), the matching fwd bit asserts and fwd_data_o=reg_data_o.
  - That register's contribution to raw_hazard_o is suppressed that cycle.
  - rd=0 never forwards.
- Undefined: no fwd ports; raw_hazard_o is as specified above, with no bypass.

Test Plan:
- Reset, then issue_rd=5 and ALU rd=5 data=0x1234 valid → alu_ready same cycle; next cycle reg_write_o=1, rd=5, data=0x00001234; following cycle data_ready_o=1 and pending[5]=0.
- mem, md and alu all valid in the same cycle → mem_ready=1 first; md accepted in cycle 2, alu in cycle 3; three consecutive reg_write_o cycles in that order.
- Load word 0x80FF7F01:
  - LB offset 3 → 0xFFFFFF80.
  - LBU offset 1 → 0x0000007F.
  - LH offset 2 → 0xFFFF80FF.
  - LHU offset 0 → 0x00007F01.
- issue rd=7, then rs1=7 → raw_hazard_o=1 until the commit of rd=7; issue_rd=7 again → waw_hazard_o=1; commit and issue of rd=7 in the same cycle → pending[7] remains 1.
- ALU rd=0 data=0xDEAD → reg_write_o stays 0, data_ready_o pulses; rst_ni pulled low the cycle after accepting rd=3 → no write to rd 3, all outputs 0.
- With RV32IM_WB_BYPASS_EN, commit rd=9 data=0xCAFE while rs2=9 → fwd_rs2_o=1, fwd_data_o=0xCAFE, raw_hazard_o=0.
